// File: rtl/tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tracker_pkg
// Description : Constants and types shared across the tracker datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package tracker_pkg;

  localparam int VGA_WIDTH      = 640;
  localparam int VGA_HEIGHT     = 480;
  localparam int TEMPLATE_WIDTH = 32;
  localparam int SCORE_W        = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage : tracker_pkg
`default_nettype wire

// File: rtl/coord_center_clamp.sv
`default_nettype none
// ============================================================================
// Module      : coord_center_clamp
// Description : Converts a template top-left coordinate into its centre,
//               saturating at LIMIT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module coord_center_clamp #(
  parameter int OFFSET = 16,
  parameter int LIMIT  = 640
) (
  input  logic [9:0] top_left,
  output logic [9:0] center
);

  // One extra bit so coordinates near 1023 cannot wrap before the clamp.
  logic [10:0] w_sum;

  assign w_sum  = {1'b0, top_left} + 11'(OFFSET);
  assign center = (w_sum > 11'(LIMIT - 1)) ? 10'(LIMIT - 1) : w_sum[9:0];

endmodule : coord_center_clamp
`default_nettype wire

// File: rtl/max_finder.sv
`default_nettype none
// ============================================================================
// Module      : max_finder
// Description : Tracks the best template-match score within a frame and
//               reports the clamped template centre one cycle after REPORT.
// Revision    : 1.0 - initial release
// ============================================================================
module max_finder #(
  parameter int SCORE_W        = tracker_pkg::SCORE_W,
  parameter int TEMPLATE_WIDTH = tracker_pkg::TEMPLATE_WIDTH,
  parameter int VGA_WIDTH      = tracker_pkg::VGA_WIDTH,
  parameter int VGA_HEIGHT     = tracker_pkg::VGA_HEIGHT,
  parameter int MIN_SCORE      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         score_x,
  input  logic [9:0]         score_y,
  output logic [9:0]         max_x,
  output logic [9:0]         max_y,
  output logic [SCORE_W-1:0] max_score,
  output logic               max_ready,
  output logic               found
);

  import tracker_pkg::*;

  localparam logic [SCORE_W-1:0] C_MIN_SCORE = SCORE_W'(MIN_SCORE);
  localparam logic [9:0]         C_RST_X     = 10'(VGA_WIDTH / 2);
  localparam logic [9:0]         C_RST_Y     = 10'(VGA_HEIGHT / 2);

  state_t             r_state;
  logic [SCORE_W-1:0] r_best_score;
  logic [9:0]         r_best_x;
  logic [9:0]         r_best_y;
  logic               r_best_hit;
  logic [9:0]         w_center_x;
  logic [9:0]         w_center_y;

  coord_center_clamp #(
    .OFFSET (TEMPLATE_WIDTH / 2),
    .LIMIT  (VGA_WIDTH)
  ) u_clamp_x (
    .top_left (r_best_x),
    .center   (w_center_x)
  );

  coord_center_clamp #(
    .OFFSET (TEMPLATE_WIDTH / 2),
    .LIMIT  (VGA_HEIGHT)
  ) u_clamp_y (
    .top_left (r_best_y),
    .center   (w_center_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_best_score <= C_MIN_SCORE;
      r_best_x     <= '0;
      r_best_y     <= '0;
      r_best_hit   <= 1'b0;
      max_x        <= C_RST_X;
      max_y        <= C_RST_Y;
      max_score    <= '0;
      max_ready    <= 1'b0;
      found        <= 1'b0;
    end else begin
      max_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_state      <= SCAN;
            r_best_score <= C_MIN_SCORE;
            r_best_hit   <= 1'b0;
          end
        end
        SCAN: begin
          // Strict compare keeps the earliest position on ties.
          if (score_valid && (score > r_best_score)) begin
            r_best_score <= score;
            r_best_x     <= score_x;
            r_best_y     <= score_y;
            r_best_hit   <= 1'b1;
          end
          if (frame_end) begin
            r_state <= REPORT;
          end else if (frame_start) begin
            r_best_score <= C_MIN_SCORE;
            r_best_hit   <= 1'b0;
          end
        end
        REPORT: begin
          found <= r_best_hit;
          if (r_best_hit) begin
            max_x     <= w_center_x;
            max_y     <= w_center_y;
            max_score <= r_best_score;
            max_ready <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : max_finder
`default_nettype wire

// File: tb/tb_max_finder.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_finder
// Description : Self-checking bench for max_finder: directed frames, clamp
//               vector table, randomized frames against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_finder;

  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          score_valid = 1'b0;
  logic [SW-1:0] score = '0;
  logic [9:0]    score_x = '0;
  logic [9:0]    score_y = '0;
  logic [9:0]    max_x;
  logic [9:0]    max_y;
  logic [SW-1:0] max_score;
  logic          max_ready;
  logic          found;

  max_finder dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .score_valid (score_valid),
    .score       (score),
    .score_x     (score_x),
    .score_y     (score_y),
    .max_x       (max_x),
    .max_y       (max_y),
    .max_score   (max_score),
    .max_ready   (max_ready),
    .found       (found)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  logic prev_ready = 1'b0;

  // Expected (held) output state of the reference model.
  int exp_x = 320, exp_y = 240, exp_s = 0, exp_found = 0;

  // Current frame's samples.
  int q_s[$];
  int q_x[$];
  int q_y[$];

  typedef struct {
    int x; int y; int s; int ex; int ey;
  } vec_t;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (max_ready === 1'b1) begin
      pulse_cnt++;
      check("no_back_to_back_ready", prev_ready, 0);
    end
    prev_ready = max_ready;
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic add(input int s, input int x, input int y);
    q_s.push_back(s); q_x.push_back(x); q_y.push_back(y);
  endtask

  // Start a frame, stream queued samples, end the frame, check the report.
  task automatic run_frame(input bit end_with_last);
    int best;
    int bi;
    bit hit;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < q_s.size(); i++) begin
      score_valid = 1'b1;
      score   = SW'(q_s[i]);
      score_x = 10'(q_x[i]);
      score_y = 10'(q_y[i]);
      frame_end = end_with_last && (i == q_s.size() - 1);
      @(negedge clk);
      score_valid = 1'b0;
      score   = SW'($urandom);
      score_x = 10'($urandom);
      score_y = 10'($urandom);
      if (!frame_end && $urandom_range(0, 2) == 0) @(negedge clk);
      frame_end = 1'b0;
    end
    if (!(end_with_last && q_s.size() > 0)) begin
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
    end
    // Now in the REPORT cycle.
    check("ready_low_in_report", max_ready, 0);
    best = 0;
    foreach (q_s[i]) if (q_s[i] > best) best = q_s[i];
    hit = (best > 0);
    bi = 0;
    for (int i = q_s.size() - 1; i >= 0; i--) if (q_s[i] == best) bi = i;
    if (hit) begin
      exp_x = imin(q_x[bi] + 16, 639);
      exp_y = imin(q_y[bi] + 16, 479);
      exp_s = best;
    end
    exp_found = hit;
    @(negedge clk);
    check("ready_pulse", max_ready, hit);
    check("max_x", max_x, exp_x);
    check("max_y", max_y, exp_y);
    check("max_score", max_score, exp_s);
    check("found", found, exp_found);
    @(negedge clk);
    check("ready_single_cycle", max_ready, 0);
    @(negedge clk);
    q_s.delete(); q_x.delete(); q_y.delete();
  endtask

  vec_t vt[6];

  initial begin
    int p0;
    int n;
    bit ewl;

    vt[0] = '{x: 630,  y: 470,  s: 5, ex: 639, ey: 479};
    vt[1] = '{x: 607,  y: 447,  s: 7, ex: 623, ey: 463};
    vt[2] = '{x: 623,  y: 463,  s: 9, ex: 639, ey: 479};
    vt[3] = '{x: 624,  y: 464,  s: 3, ex: 639, ey: 479};
    vt[4] = '{x: 0,    y: 0,    s: 1, ex: 16,  ey: 16};
    vt[5] = '{x: 1023, y: 1023, s: 2, ex: 639, ey: 479};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, idle with a stray sample that must be ignored.
    check("rst_max_x", max_x, 320);
    check("rst_max_y", max_y, 240);
    check("rst_max_score", max_score, 0);
    check("rst_found", found, 0);
    check("rst_ready", max_ready, 0);
    score_valid = 1'b1; score = 24'd9999; score_x = 10'd1; score_y = 10'd1;
    @(negedge clk); score_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_no_pulse", pulse_cnt, 0);

    // Basic frame.
    add(10, 100, 50); add(90, 200, 120); add(40, 300, 200);
    run_frame(1'b0);
    check("basic_x", max_x, 216);
    check("basic_y", max_y, 136);
    check("basic_score", max_score, 90);

    // Ties keep the earliest; then an all-zero frame holds outputs.
    add(70, 10, 10); add(70, 400, 300);
    run_frame(1'b0);
    check("tie_x", max_x, 26);
    check("tie_y", max_y, 26);
    p0 = pulse_cnt;
    add(0, 500, 400); add(0, 20, 20);
    run_frame(1'b1);
    check("zero_frame_no_pulse", pulse_cnt - p0, 0);
    check("zero_hold_x", max_x, 26);
    check("zero_hold_score", max_score, 70);
    check("zero_found", found, 0);

    // Clamp vector table.
    for (int i = 0; i < 6; i++) begin
      add(vt[i].s, vt[i].x, vt[i].y);
      run_frame(i[0]);
      check("table_x", max_x, vt[i].ex);
      check("table_y", max_y, vt[i].ey);
    end

    // Best score coinciding with frame_end.
    add(5, 1, 1); add(99, 630, 470);
    run_frame(1'b1);
    check("end_same_cycle_score", max_score, 99);
    check("end_same_cycle_x", max_x, 639);

    // Restart mid-scan.
    p0 = pulse_cnt;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    score_valid = 1'b1; score = 24'd500; score_x = 10'd50; score_y = 10'd50;
    @(negedge clk); score_valid = 1'b0;
    add(20, 0, 0); add(5, 3, 3);
    run_frame(1'b0);
    check("restart_x", max_x, 16);
    check("restart_y", max_y, 16);
    check("restart_score", max_score, 20);
    check("restart_one_pulse", pulse_cnt - p0, 1);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 12);
      ewl = (n > 0) && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0)
          add(int'($urandom & 32'h00FF_FFFF), $urandom_range(0, 1023), $urandom_range(0, 1023));
        else
          add($urandom_range(0, 20), $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      run_frame(ewl);
    end

    // Async reset mid-scan.
    p0 = pulse_cnt;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    score_valid = 1'b1; score = 24'd900; score_x = 10'd5; score_y = 10'd5;
    @(negedge clk); score_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_x", max_x, 320);
    check("async_rst_y", max_y, 240);
    check("async_rst_score", max_score, 0);
    check("async_rst_found", found, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); frame_end = 1'b1;
    @(negedge clk); frame_end = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_abort_no_pulse", pulse_cnt - p0, 0);
    check("rst_abort_hold_x", max_x, 320);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_max_finder
`default_nettype wire
